// File: rtl/agu_issue_ctrl.sv
// AGU issue controller: buffers issued address ops in a 4-deep FIFO and walks them
// one at a time through a single-outstanding memory port, broadcasting each completion.
module agu_issue_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       valid_op_awake,
  input  logic [4:0] Pa_awake,
  input  logic [4:0] Imm_awake,
  input  logic [4:0] tag_ROB_awake,
  input  logic [4:0] Pw_awake,
  input  logic       mode_awake,
  input  logic [7:0] base_val,
  input  logic [7:0] st_data,
  output logic       freeze_back,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_gnt,
  input  logic       mem_rvalid,
  input  logic [7:0] mem_rdata,
  output logic       valid_Result_ls,
  output logic       mode_ls,
  output logic [4:0] Pw_Result_ls,
  output logic [4:0] tag_ROB_done,
  output logic [7:0] result_data,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t     r_state;
  logic [1:0] r_rdPtr;
  logic [1:0] r_wrPtr;
  logic [2:0] r_count;
  logic       r_overflow;
  logic [7:0] r_resultData;

  logic       r_fifoMode [4];
  logic [4:0] r_fifoPw   [4];
  logic [4:0] r_fifoTag  [4];
  logic [7:0] r_fifoAddr [4];
  logic [7:0] r_fifoData [4];

  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_headMode;
  logic [7:0] w_addr;
  logic       w_unusedPa;

  // The source register index is not needed once the base value has been read.
  assign w_unusedPa = ^Pa_awake;

  assign w_addr     = base_val + {3'b000, Imm_awake};
  assign w_full     = (r_count == 3'd4);
  assign w_headMode = r_fifoMode[r_rdPtr];
  assign w_push     = valid_op_awake && !w_full && !flush && (r_state != DRAIN);
  assign w_pop      = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMode[r_wrPtr] <= mode_awake;
      r_fifoPw[r_wrPtr]   <= Pw_awake;
      r_fifoTag[r_wrPtr]  <= tag_ROB_awake;
      r_fifoAddr[r_wrPtr] <= w_addr;
      r_fifoData[r_wrPtr] <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_rdPtr      <= 2'd0;
      r_wrPtr      <= 2'd0;
      r_count      <= 3'd0;
      r_overflow   <= 1'b0;
      r_resultData <= 8'h00;
    end else begin
      if (valid_op_awake && w_full && !flush)
        r_overflow <= 1'b1;

      if (flush) begin
        r_rdPtr <= 2'd0;
        r_wrPtr <= 2'd0;
        r_count <= 3'd0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + 2'd1;
        if (w_pop)  r_rdPtr <= r_rdPtr + 2'd1;
        r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end

      // A flushed load that memory already accepted still owes a response; DRAIN swallows it.
      case (r_state)
        IDLE:  if (!flush && (r_count != 3'd0)) r_state <= REQ;
        REQ: begin
          if (mem_gnt) begin
            if (w_headMode) r_state <= flush ? DRAIN : WAIT;
            else            r_state <= flush ? IDLE  : DONE;
          end else if (flush) begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_resultData <= mem_rdata;
            r_state      <= flush ? IDLE : DONE;
          end else if (flush) begin
            r_state <= DRAIN;
          end
        end
        DONE:    r_state <= IDLE;
        DRAIN:   if (mem_rvalid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req         = (r_state == REQ);
    mem_we          = mem_req && !w_headMode;
    mem_addr        = mem_req ? r_fifoAddr[r_rdPtr] : 8'h00;
    mem_wdata       = mem_req ? r_fifoData[r_rdPtr] : 8'h00;
    valid_Result_ls = (r_state == DONE);
    mode_ls         = valid_Result_ls ? w_headMode : 1'b0;
    Pw_Result_ls    = valid_Result_ls ? r_fifoPw[r_rdPtr] : 5'd0;
    tag_ROB_done    = valid_Result_ls ? r_fifoTag[r_rdPtr] : 5'd0;
    result_data     = valid_Result_ls ? r_resultData : 8'h00;
  end

  // One slot of slack covers the op the reservation station has already registered.
  assign freeze_back = (r_count >= 3'd3) || (r_state == DRAIN);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_agu_issue_ctrl.sv
// Scoreboard bench for agu_issue_ctrl: directed ops push expected memory requests and
// completions into queues; a negedge monitor pops and compares what the DUT presents.
`timescale 1ns/1ps
module tb_agu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       valid_op_awake = 1'b0;
  logic [4:0] Pa_awake = 5'd0;
  logic [4:0] Imm_awake = 5'd0;
  logic [4:0] tag_ROB_awake = 5'd0;
  logic [4:0] Pw_awake = 5'd0;
  logic       mode_awake = 1'b0;
  logic [7:0] base_val = 8'h00;
  logic [7:0] st_data = 8'h00;
  logic       freeze_back;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_gnt = 1'b0;
  logic       mem_rvalid = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       valid_Result_ls;
  logic       mode_ls;
  logic [4:0] Pw_Result_ls;
  logic [4:0] tag_ROB_done;
  logic [7:0] result_data;
  logic       overflow;

  agu_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_op_awake(valid_op_awake),
    .Pa_awake(Pa_awake), .Imm_awake(Imm_awake), .tag_ROB_awake(tag_ROB_awake),
    .Pw_awake(Pw_awake), .mode_awake(mode_awake), .base_val(base_val), .st_data(st_data),
    .freeze_back(freeze_back), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .valid_Result_ls(valid_Result_ls), .mode_ls(mode_ls), .Pw_Result_ls(Pw_Result_ls),
    .tag_ROB_done(tag_ROB_done), .result_data(result_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } memExp_t;
  typedef struct { logic mode; logic [4:0] pw; logic [4:0] tag; logic [7:0] data; } resExp_t;

  memExp_t expMemQ[$];
  resExp_t expResQ[$];
  int nChecks = 0;
  int nPassed = 0;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nChecks++;
    if (actual === expected) nPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic flagFailure(input string name, input logic [7:0] actual);
    nChecks++;
    $display("[TB] FAIL %s: got %0h, expected no event at %0t", name, actual, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearScoreboard();
    expMemQ.delete();
    expResQ.delete();
  endtask

  // Present one op for one clock edge; expected address/data are hand-computed by the caller.
  task automatic applyStimulus(input logic mode, input logic [4:0] pw, input logic [4:0] tag,
                               input logic [4:0] imm, input logic [7:0] base, input logic [7:0] data,
                               input logic [7:0] expAddr, input logic [7:0] expData, input bit expectIt);
    memExp_t m;
    resExp_t r;
    valid_op_awake = 1'b1;
    mode_awake     = mode;
    Pw_awake       = pw;
    tag_ROB_awake  = tag;
    Imm_awake      = imm;
    base_val       = base;
    st_data        = data;
    Pa_awake       = pw ^ 5'h15;
    if (expectIt) begin
      m.we = !mode; m.addr = expAddr; m.wdata = data;
      r.mode = mode; r.pw = pw; r.tag = tag; r.data = expData;
      expMemQ.push_back(m);
      expResQ.push_back(r);
    end
    tick();
    valid_op_awake = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Freeze"}, freeze_back, 8'h00);
    checkOutput({tag, "MemReq"}, mem_req, 8'h00);
    checkOutput({tag, "MemWe"}, mem_we, 8'h00);
    checkOutput({tag, "MemAddr"}, mem_addr, 8'h00);
    checkOutput({tag, "MemWdata"}, mem_wdata, 8'h00);
    checkOutput({tag, "Valid"}, valid_Result_ls, 8'h00);
    checkOutput({tag, "ModeLs"}, mode_ls, 8'h00);
    checkOutput({tag, "PwRes"}, {3'b000, Pw_Result_ls}, 8'h00);
    checkOutput({tag, "TagDone"}, {3'b000, tag_ROB_done}, 8'h00);
    checkOutput({tag, "ResData"}, result_data, 8'h00);
    checkOutput({tag, "Overflow"}, overflow, 8'h00);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expResQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (expResQ.size() != 0) flagFailure("drainTimeout", 8'(expResQ.size()));
    tick();
  endtask

  // Monitor: a new memory request is a rising mem_req; every broadcast cycle pops one completion.
  initial begin : monitor
    logic    prevReq;
    memExp_t m;
    resExp_t r;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req && !prevReq) begin
          if (expMemQ.size() == 0) flagFailure("unexpectedMemReq", mem_addr);
          else begin
            m = expMemQ.pop_front();
            checkOutput("memWe", mem_we, m.we);
            checkOutput("memAddr", mem_addr, m.addr);
            checkOutput("memWdata", mem_wdata, m.wdata);
          end
        end
        if (valid_Result_ls) begin
          if (expResQ.size() == 0) flagFailure("unexpectedBroadcast", {3'b000, tag_ROB_done});
          else begin
            r = expResQ.pop_front();
            checkOutput("resMode", mode_ls, r.mode);
            checkOutput("resPw", {3'b000, Pw_Result_ls}, {3'b000, r.pw});
            checkOutput("resTag", {3'b000, tag_ROB_done}, {3'b000, r.tag});
            if (r.mode) checkOutput("resData", result_data, r.data);
          end
        end
      end
      prevReq = mem_req && rst;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic       t3Freeze [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       t3Ovf    [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] t5Base   [6] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
  logic [7:0] t5Addr   [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin : stimulus
    int issued;
    $display("[TB] starting agu_issue_ctrl bench");

    // Reset state
    rst = 1'b0;
    tick(); tick();
    checkAllZero("rst");
    rst = 1'b1;
    tick();

    // Store with wrapping address, grant tied high
    mem_gnt = 1'b1;
    applyStimulus(1'b0, 5'd3, 5'd1, 5'h1F, 8'hF0, 8'h5A, 8'h0F, 8'h00, 1'b1);
    checkOutput("t1NoReqCycle1", mem_req, 8'h00);
    tick();
    checkOutput("t1Req", mem_req, 8'h01);
    checkOutput("t1We", mem_we, 8'h01);
    checkOutput("t1Addr", mem_addr, 8'h0F);
    checkOutput("t1Wdata", mem_wdata, 8'h5A);
    tick();
    checkOutput("t1Valid", valid_Result_ls, 8'h01);
    checkOutput("t1Mode", mode_ls, 8'h00);
    tick();
    checkOutput("t1ValidDrop", valid_Result_ls, 8'h00);
    tick();

    // Load: stray rvalid while idle is ignored, real data arrives 3 cycles after grant
    applyStimulus(1'b1, 5'd7, 5'd12, 5'h04, 8'h10, 8'h00, 8'h14, 8'hA5, 1'b1);
    mem_rvalid = 1'b1; mem_rdata = 8'hFF;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("t2Req", mem_req, 8'h01);
    checkOutput("t2WeLoad", mem_we, 8'h00);
    tick();
    checkOutput("t2WaitNoReq", mem_req, 8'h00);
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("t2Valid", valid_Result_ls, 8'h01);
    checkOutput("t2Data", result_data, 8'hA5);
    checkOutput("t2Pw", {3'b000, Pw_Result_ls}, 8'd7);
    checkOutput("t2Tag", {3'b000, tag_ROB_done}, 8'd12);
    checkOutput("t2Mode", mode_ls, 8'h01);
    tick();
    checkOutput("t2SingleCycle", valid_Result_ls, 8'h00);
    checkOutput("t2DataCleared", result_data, 8'h00);

    // Grant withheld: fill the FIFO, fifth op overflows
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'(i + 1), 5'(i), 5'(i), 8'h20, 8'(8'h10 + i), 8'h20, 8'h00, i == 0);
      checkOutput($sformatf("t3Freeze%0d", i), freeze_back, {7'd0, t3Freeze[i]});
      checkOutput($sformatf("t3Ovf%0d", i), overflow, {7'd0, t3Ovf[i]});
    end
    checkOutput("t3HeadAddr", mem_addr, 8'h20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clearScoreboard();
    checkOutput("t3FlushFreeze", freeze_back, 8'h00);
    checkOutput("t3OvfSticky", overflow, 8'h01);
    checkOutput("t3FlushNoReq", mem_req, 8'h00);
    tick();
    checkOutput("t3EmptyNoReq", mem_req, 8'h00);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("t3OvfReset", overflow, 8'h00);
    tick();

    // Flush during WAIT with two ops queued
    mem_gnt = 1'b1;
    applyStimulus(1'b1, 5'd2, 5'd20, 5'h1F, 8'h80, 8'h00, 8'h9F, 8'h00, 1'b1);
    applyStimulus(1'b0, 5'd4, 5'd21, 5'h01, 8'h01, 8'h33, 8'h02, 8'h00, 1'b0);
    tick();
    checkOutput("t4InWait", mem_req, 8'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clearScoreboard();
    checkOutput("t4DrainFreeze", freeze_back, 8'h01);
    checkOutput("t4DrainNoReq", mem_req, 8'h00);
    checkOutput("t4DrainNoValid", valid_Result_ls, 8'h00);
    tick();
    checkOutput("t4DrainHold", freeze_back, 8'h01);
    mem_rvalid = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("t4IdleFreeze", freeze_back, 8'h00);
    checkOutput("t4IdleNoValid", valid_Result_ls, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t4NoReq%0d", i), mem_req, 8'h00);
    end
    applyStimulus(1'b0, 5'd9, 5'd22, 5'h02, 8'h40, 8'hEE, 8'h42, 8'h00, 1'b1);
    waitDrain(20);

    // Six stores across pointer wrap, issuing whenever a slot is free
    issued = 0;
    for (int cyc = 0; cyc < 80 && issued < 6; cyc++) begin
      if (!freeze_back || valid_Result_ls) begin
        applyStimulus(1'b0, 5'(issued + 8), 5'(issued), 5'(issued), t5Base[issued],
                      8'(8'hC0 + issued), t5Addr[issued], 8'h00, 1'b1);
        issued++;
      end else begin
        tick();
      end
    end
    checkOutput("t5AllIssued", 8'(issued), 8'd6);
    waitDrain(40);
    checkOutput("t5NoOverflow", overflow, 8'h00);

    // Reset during REQ, then a stale response
    mem_gnt = 1'b0;
    applyStimulus(1'b1, 5'd5, 5'd30, 5'h00, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1);
    tick();
    checkOutput("t6InReq", mem_req, 8'h01);
    rst = 1'b0;
    tick();
    checkAllZero("t6");
    rst = 1'b1;
    clearScoreboard();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'h5C;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6NoValid%0d", i), valid_Result_ls, 8'h00);
      checkOutput($sformatf("t6NoReq%0d", i), mem_req, 8'h00);
      tick();
    end

    checkOutput("memQueueEmpty", 8'(expMemQ.size()), 8'd0);
    checkOutput("resQueueEmpty", 8'(expResQ.size()), 8'd0);
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
